// File: rtl/isa_memory_responder_if.sv
// Bus bundle between the 16-bit core / boot stream source and the memory responder.
// The master side is the core plus the boot-stream source. The slave side is the responder.
interface isa_memory_responder_if;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        load_done;
    logic        load_err;
    logic        cpu_rst_n;
    logic [15:0] program_address;
    logic [15:0] instruction;
    logic [15:0] address;
    logic [15:0] wr_data;
    logic        mem_w;
    logic [15:0] rd_data;

    modport master (
        output load_data, load_valid, program_address, address, wr_data, mem_w,
        input  load_ready, load_done, load_err, cpu_rst_n, instruction, rd_data
    );

    modport slave (
        input  load_data, load_valid, program_address, address, wr_data, mem_w,
        output load_ready, load_done, load_err, cpu_rst_n, instruction, rd_data
    );
endinterface

// File: rtl/isa_memory_responder.sv
// Memory responder for the single-cycle 16-bit core.
// Instruction and data RAMs are read combinationally.
// A boot loader fills instruction RAM from a length-prefixed byte stream.
// The core is held in reset until that load completes.
module isa_memory_responder #(
    parameter int IMEM_AW = 11,
    parameter int DMEM_AW = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    isa_memory_responder_if.slave  bus
);
    typedef enum logic [2:0] {LEN_HI, LEN_LO, WORD_HI, WORD_LO, RUN, ERR} state_t;

    localparam logic [16:0] IMEM_WORDS = 17'(1) << IMEM_AW;

    state_t      state, state_nx;
    logic [15:0] n_q;
    logic [15:0] cnt_q;
    logic [7:0]  hi_q;
    logic        loading;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] cnt_inc;
    logic        imem_oob;
    logic        dmem_oob;

    logic [15:0] imem [2**IMEM_AW];
    logic [15:0] dmem [2**DMEM_AW];

    assign loading  = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == WORD_HI) || (state == WORD_LO);
    assign accept   = bus.load_valid && loading;
    assign len_full = {n_q[15:8], bus.load_data};
    assign cnt_inc  = cnt_q + 16'd1;
    assign imem_oob = |bus.program_address[15:IMEM_AW];
    assign dmem_oob = |bus.address[15:DMEM_AW];

    assign bus.load_ready = loading;
    assign bus.load_done  = (state == RUN);
    assign bus.load_err   = (state == ERR);
    // Gate with rst so the core sees reset in the same cycle rst is raised, even from RUN.
    assign bus.cpu_rst_n  = (state == RUN) && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LEN_HI;
        else     state <= state_nx;
    end

    // Next-state logic for the boot-stream parser.
    always_comb begin
        state_nx = state;
        case (state)
            LEN_HI:  if (accept) state_nx = LEN_LO;
            LEN_LO:  if (accept) begin
                         if (len_full == 16'd0)                 state_nx = RUN;
                         else if ({1'b0, len_full} > IMEM_WORDS) state_nx = ERR;
                         else                                    state_nx = WORD_HI;
                     end
            WORD_HI: if (accept) state_nx = WORD_LO;
            WORD_LO: if (accept) state_nx = (cnt_inc == n_q) ? RUN : WORD_HI;
            RUN:     state_nx = RUN;
            ERR:     state_nx = ERR;
            default: state_nx = LEN_HI;
        endcase
    end

    // Length, word counter and high-byte latches. Each one advances only on an accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            cnt_q <= '0;
            hi_q  <= '0;
        end else if (accept) begin
            case (state)
                LEN_HI:  n_q[15:8] <= bus.load_data;
                LEN_LO:  begin n_q[7:0] <= bus.load_data; cnt_q <= '0; end
                WORD_HI: hi_q <= bus.load_data;
                WORD_LO: cnt_q <= cnt_inc;
                default: ;
            endcase
        end
    end

    // Instruction RAM write. A word lands on the edge that accepts its low byte.
    always_ff @(posedge clk) begin
        if (!rst && accept && (state == WORD_LO))
            imem[cnt_q[IMEM_AW-1:0]] <= {hi_q, bus.load_data};
    end

    // Data RAM write. Only a running core may store, and only to in-range addresses.
    always_ff @(posedge clk) begin
        if (bus.mem_w && (state == RUN) && !dmem_oob)
            dmem[bus.address[DMEM_AW-1:0]] <= bus.wr_data;
    end

    assign bus.instruction = imem_oob ? 16'h0000 : imem[bus.program_address[IMEM_AW-1:0]];
    assign bus.rd_data     = dmem_oob ? 16'h0000 : dmem[bus.address[DMEM_AW-1:0]];
endmodule

// File: tb/tb_isa_memory_responder.sv
// Scoreboard bench for isa_memory_responder.
// Stimulus pushes expectations derived from a stream-level model.
// A negedge monitor pops each expectation and compares it against the live outputs.
module tb_isa_memory_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    isa_memory_responder_if bus ();
    isa_memory_responder #(.IMEM_AW(11), .DMEM_AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int SEL_INSTR = 0, SEL_RD = 1, SEL_RDY = 2, SEL_DONE = 3, SEL_ERR = 4, SEL_CRST = 5;

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   passed = 0;

    // Reference model, kept at the level of the stream format.
    logic [7:0]  stream[$];
    int          mode;            // 0 loading, 1 run, 2 err
    logic [15:0] im [2048];
    bit          imv [2048];
    logic [15:0] dm [1024];
    bit          dmv [1024];
    int          mdl_acc = 0;
    int          acc_cnt = 0;

    // Count real handshakes so extra or missing accepts show up.
    always @(posedge clk) if (!rst && bus.load_valid && bus.load_ready) acc_cnt++;

    // Monitor: compare every queued expectation against the outputs presented this cycle.
    always @(negedge clk) begin
        while (sbq.size() != 0) begin
            exp_t e;
            logic [15:0] got;
            e = sbq.pop_front();
            case (e.sel)
                SEL_INSTR: got = bus.instruction;
                SEL_RD:    got = bus.rd_data;
                SEL_RDY:   got = {15'd0, bus.load_ready};
                SEL_DONE:  got = {15'd0, bus.load_done};
                SEL_ERR:   got = {15'd0, bus.load_err};
                default:   got = {15'd0, bus.cpu_rst_n};
            endcase
            total++;
            if (got === e.exp) passed++;
            else $display("FAIL %s got=%h exp=%h t=%0t", e.name, got, e.exp, $time);
        end
    end

    task automatic push(input int sel, input logic [15:0] v, input string name);
        exp_t e;
        e.sel = sel; e.exp = v; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_status(input string tag);
        push(SEL_RDY,  {15'd0, mode == 0}, {tag, ".load_ready"});
        push(SEL_DONE, {15'd0, mode == 1}, {tag, ".load_done"});
        push(SEL_ERR,  {15'd0, mode == 2}, {tag, ".load_err"});
        push(SEL_CRST, {15'd0, mode == 1}, {tag, ".cpu_rst_n"});
    endtask

    // Stream-level model of an accepted byte.
    task automatic model_byte(input logic [7:0] b);
        int n, c;
        if (mode != 0) return;
        stream.push_back(b);
        mdl_acc++;
        c = stream.size();
        if (c < 2) return;
        n = {stream[0], stream[1]};
        if (c >= 4 && (c % 2) == 0) begin
            im[(c - 4) / 2]  = {stream[c-2], stream[c-1]};
            imv[(c - 4) / 2] = 1'b1;
        end
        if (n > 2048)            mode = 2;
        else if (c == 2 + 2 * n) mode = 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.mem_w = 1'b0;
        push(SEL_CRST, 16'd0, "rst_cycle.cpu_rst_n");
        step();
        step();
        rst = 1'b0;
        stream.delete();
        mode = 0;
        push_status("after_rst");
        step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        bus.load_valid = 1'b0;
        repeat (gap) step();
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (bus.load_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        bus.load_valid = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL accept_timeout got=no_accept exp=accept byte=%h", b);
        end
        model_byte(b);
    endtask

    task automatic junk(input int k);
        repeat (k) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'($urandom);
            step();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic chk_imem(input logic [15:0] pc, input string name);
        bus.program_address = pc;
        if (pc[15:11] != 0)  push(SEL_INSTR, 16'h0000, name);
        else if (imv[pc])    push(SEL_INSTR, im[pc], name);
        step();
    endtask

    task automatic dm_op(input logic [15:0] a, input logic [15:0] d, input bit w, input string name);
        bus.address = a;
        bus.wr_data = d;
        bus.mem_w   = w;
        if (a[15:10] != 0)  push(SEL_RD, 16'h0000, name);
        else if (dmv[a])    push(SEL_RD, dm[a], name);
        step();
        bus.mem_w = 1'b0;
        if (w && mode == 1 && a[15:10] == 0) begin
            dm[a] = d; dmv[a] = 1'b1;
        end
    endtask

    task automatic chk_acc(input string name);
        total++;
        if (acc_cnt == mdl_acc) passed++;
        else $display("FAIL %s got=%0d exp=%0d", name, acc_cnt, mdl_acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] w;
        rst = 1'b1;
        mode = 0;
        bus.load_data = '0; bus.load_valid = 1'b0;
        bus.program_address = '0; bus.address = '0; bus.wr_data = '0; bus.mem_w = 1'b0;
        step();
        do_reset();

        // Two words, valid every cycle.
        foreach (stream[i]) ;
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h12, 0);
        send_byte(8'h34, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        push_status("t1");
        chk_imem(16'h0000, "t1.imem0");
        chk_imem(16'h0001, "t1.imem1");

        // Empty program goes straight to RUN, and imem keeps its old contents.
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        push_status("t2");
        chk_imem(16'h0000, "t2.imem0_kept");
        chk_imem(16'h0800, "t2.pc_oob");

        // Gapped stream.
        do_reset();
        send_byte(8'h00, 3); send_byte(8'h01, 3); send_byte(8'h56, 3); send_byte(8'h78, 3);
        push_status("t3");
        chk_imem(16'h0000, "t3.imem0");
        chk_acc("t3.accept_count");

        // Oversized length, then bytes that must be ignored.
        do_reset();
        send_byte(8'h08, 0); send_byte(8'h01, 0);
        push_status("t4");
        junk(5);
        push_status("t4.after_junk");
        step();
        chk_acc("t4.accept_count");

        // Reset in the middle of a load, then a fresh stream.
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h12, 0);
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h9A, 0); send_byte(8'hBC, 0);
        push_status("t6");
        chk_imem(16'h0000, "t6.imem0");
        chk_imem(16'h0001, "t6.imem1_kept");

        // Data memory: read-during-write, out-of-range, and a store while loading.
        dm_op(16'h0005, 16'h1111, 1'b1, "t5.w5");
        dm_op(16'h0000, 16'h2222, 1'b1, "t5.w0");
        dm_op(16'h0005, 16'hBEEF, 1'b1, "t5.rdw_old");
        dm_op(16'h0005, 16'h0000, 1'b0, "t5.rdw_new");
        dm_op(16'h0400, 16'hDEAD, 1'b1, "t5.oob_read");
        dm_op(16'h0000, 16'h0000, 1'b0, "t5.oob_no_alias");
        do_reset();
        dm_op(16'h0005, 16'h9999, 1'b1, "t5.w_during_load");
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        dm_op(16'h0005, 16'h0000, 1'b0, "t5.dmem_kept");

        // Randomized load and randomized core traffic.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 24);
            send_byte(8'(n >> 8), $urandom_range(0, 2));
            send_byte(8'(n), $urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                send_byte(w[15:8], $urandom_range(0, 2));
                send_byte(w[7:0], $urandom_range(0, 2));
            end
            push_status("rnd.status");
            for (int i = 0; i < 6; i++) chk_imem(16'($urandom_range(0, n - 1)), "rnd.imem");
            chk_imem(16'h0800 | 16'($urandom_range(0, 16'hF7FF)), "rnd.pc_oob");
            for (int i = 0; i < 20; i++) begin
                logic [15:0] a;
                a = ($urandom_range(0, 7) == 0) ? (16'h0400 | 16'($urandom))
                                                : 16'($urandom_range(0, 15));
                dm_op(a, 16'($urandom), bit'($urandom_range(0, 1)), "rnd.dmem");
            end
            chk_acc("rnd.accept_count");
        end

        step();
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
